regfile_wb_arbiter: RTL

- Sits between two writeback sources (A: ALU, B: load unit) and the single write port of the 32x32 register file (regfile).
- Arbitrates the two sources round-robin and drives a registered write port: WriteRegister / WriteData / RegWrite.
- Maintains a pending-write scoreboard so issue logic can detect RAW hazards and block WAW issue.

---
 rtl/regfile_wb_arbiter_pkg.sv | 28 ++
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter_wb_scoreboard.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 82 ++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Source-select encoding and the scoreboard popcount helper live here.
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int CNT_W  = 6;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic logic [CNT_W-1:0] popcount(
        input logic [NREG-1:0] v
    );
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// One writeback source channel: valid/ready handshake plus
// destination register and data.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output rd,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  rd,
        input  data,
        output ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue,
// cleared on regfile commit; bit 0 is hardwired to zero.
module regfile_wb_arbiter_wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              issue_ready,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_reg,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] chk_reg,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              chk_pending,
    output logic [CNT_W-1:0]  pending_count
);

    logic [NREG-1:0] bits;
    logic [NREG-1:0] bits_nxt;
    logic            issue_zero;
    logic            set_en;

    assign issue_zero  = (issue_reg == ZERO_REG);
    assign issue_ready = ~bits[issue_reg] | issue_zero;
    assign set_en      = issue_valid & issue_ready & ~issue_zero;

    assign rs1_pending = bits[rs1];
    assign rs2_pending = bits[rs2];
    assign chk_pending = bits[chk_reg];

    always_comb begin
        bits_nxt = bits;
        if (clr_en) begin
            bits_nxt[clr_reg] = 1'b0;
        end
        if (set_en) begin
            bits_nxt[issue_reg] = 1'b1;
        end
        bits_nxt[0] = 1'b0;
    end

    // count tracks the next vector so it lands in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits          <= '0;
            pending_count <= '0;
        end else begin
            bits          <= bits_nxt;
            pending_count <= popcount(bits_nxt);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of ALU/load writebacks onto the single
// registered regfile write port, with pending-write scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  a,
    regfile_wb_arbiter_if.slave  b,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_reg,
    output logic                 issue_ready,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    output logic                 rs1_pending,
    output logic                 rs2_pending,
    output logic                 RegWrite,
    output logic [ADDR_W-1:0]    WriteRegister,
    output logic [DATA_W-1:0]    WriteData,
    output logic [CNT_W-1:0]     pending_count,
    output logic                 err_unexpected
);

    src_e              prio;
    logic              grant_a;
    logic              grant_b;
    logic              hs;
    logic [ADDR_W-1:0] win_reg;
    logic [DATA_W-1:0] win_data;
    logic              win_pending;

    assign grant_a = a.valid & (~b.valid | (prio == SRC_A));
    assign grant_b = b.valid & (~a.valid | (prio == SRC_B));

    assign a.ready = grant_a;
    assign b.ready = grant_b;

    assign hs       = grant_a | grant_b;
    assign win_reg  = grant_b ? b.rd   : a.rd;
    assign win_data = grant_b ? b.data : a.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio           <= SRC_A;
            RegWrite       <= 1'b0;
            WriteRegister  <= '0;
            WriteData      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            RegWrite <= hs & (win_reg != ZERO_REG);
            if (hs) begin
                WriteRegister <= win_reg;
                WriteData     <= win_data;
            end
            // only contention moves the pointer, toward the loser
            if (a.valid & b.valid) begin
                prio <= grant_a ? SRC_B : SRC_A;
            end
            if (hs & (win_reg != ZERO_REG) & ~win_pending) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    regfile_wb_arbiter_wb_scoreboard u_wb_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_reg     (issue_reg),
        .issue_ready   (issue_ready),
        .clr_en        (RegWrite),
        .clr_reg       (WriteRegister),
        .rs1           (rs1),
        .rs2           (rs2),
        .chk_reg       (win_reg),
        .rs1_pending   (rs1_pending),
        .rs2_pending   (rs2_pending),
        .chk_pending   (win_pending),
        .pending_count (pending_count)
    );

endmodule
